// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the common data bus (CDB) arbiter slice:
//   - ROB position, data and address widths/types
//   - TRUE/FALSE constants
//   - CDB source encodings (CDB_SRC_ALU / CDB_SRC_LSB)
//   - packed entry formats held in the per-source queues
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int ROB_POS_W = 5;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;

  typedef logic [ROB_POS_W-1:0] rob_wrap_pos_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ADDR_W-1:0]    addr_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Encoding of cdb_src on the broadcast bus.
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  // Full result as broadcast on the CDB (ALU queue entries use all fields).
  typedef struct packed {
    rob_wrap_pos_t rob_pos;
    data_t         val;
    logic          jump;
    addr_t         pc;
  } cdb_entry_t;

  // Load results carry no branch information, so the LSB queue is narrower.
  typedef struct packed {
    rob_wrap_pos_t rob_pos;
    data_t         val;
  } lsb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Generic circular FIFO used as a per-source result queue in front of the CDB.
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries (power of two, >= 2); pointers wrap modulo DEPTH
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (pointers and count to 0)
//   en         global enable; low freezes pointers, count and storage
//   flush      empties the queue (takes precedence over push/pop)
//   push       write push_data at the tail (ignored when full)
//   push_data  entry to write
//   pop        advance the head (ignored when empty)
//   head       entry at the head (valid when count != 0)
//   count      number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module cdb_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (en) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        // Full is judged on the current count, so a same-edge pop never
        // makes room for a push.
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop  && (count_q != '0);
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count qualifies every read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Queues ALU and load (LSB) results and broadcasts at most one per cycle on
// the registered common data bus.
//
// Build option: CDB_ROUND_ROBIN_EN
//   defined   -> on contention the source not granted last wins
//   undefined -> ALU always wins on contention
//
// Parameters:
//   QDEPTH  entries per source queue (power of two, >= 2)
// Ports:
//   clk, rst         clock / synchronous active-high reset
//   rdy              global ready; low freezes all state and outputs
//   clr              misprediction flush: empties queues, drops inputs
//   alu_*            ALU result input (valid, rob_pos, val, jump, pc)
//   alu_stall        ALU queue full; a valid presented now is dropped
//   lsb_*            load result input (valid, rob_pos, val)
//   lsb_stall        LSB queue full; a valid presented now is dropped
//   cdb_*            registered broadcast; cdb_src 0=ALU, 1=LSB
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 alu_valid,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  input  logic [DATA_W-1:0]    alu_val,
  input  logic                 alu_jump,
  input  logic [ADDR_W-1:0]    alu_pc,
  output logic                 alu_stall,
  input  logic                 lsb_valid,
  input  logic [ROB_POS_W-1:0] lsb_rob_pos,
  input  logic [DATA_W-1:0]    lsb_val,
  output logic                 lsb_stall,
  output logic                 cdb_valid,
  output logic                 cdb_src,
  output logic [ROB_POS_W-1:0] cdb_rob_pos,
  output logic [DATA_W-1:0]    cdb_val,
  output logic                 cdb_jump,
  output logic [ADDR_W-1:0]    cdb_pc
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  cdb_entry_t       alu_in, alu_head;
  lsb_entry_t       lsb_in, lsb_head;
  logic [CNT_W-1:0] alu_count, lsb_count;
  logic             alu_push, lsb_push;
  logic             alu_ne, lsb_ne;
  logic             grant_alu, grant_lsb;

  // Simulation-visible flags: a producer presented a result into a full
  // queue and it was discarded.
  logic             alu_drop, lsb_drop;

  logic             cdb_valid_q, cdb_valid_d;
  logic             cdb_src_q, cdb_src_d;
  cdb_entry_t       cdb_entry_q, cdb_entry_d;

  assign alu_stall = (alu_count == CNT_W'(QDEPTH));
  assign lsb_stall = (lsb_count == CNT_W'(QDEPTH));
  assign alu_ne    = (alu_count != '0);
  assign lsb_ne    = (lsb_count != '0);

  assign alu_in = '{rob_pos: alu_rob_pos, val: alu_val, jump: alu_jump, pc: alu_pc};
  assign lsb_in = '{rob_pos: lsb_rob_pos, val: lsb_val};

  // clr discards anything presented in the same cycle.
  assign alu_push = alu_valid & ~alu_stall & ~clr;
  assign lsb_push = lsb_valid & ~lsb_stall & ~clr;

  assign alu_drop = alu_valid & alu_stall & rdy & ~clr & ~rst;
  assign lsb_drop = lsb_valid & lsb_stall & rdy & ~clr & ~rst;

  cdb_fifo #(
    .WIDTH ($bits(cdb_entry_t)),
    .DEPTH (QDEPTH)
  ) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .flush     (clr),
    .push      (alu_push),
    .push_data (alu_in),
    .pop       (grant_alu),
    .head      (alu_head),
    .count     (alu_count)
  );

  cdb_fifo #(
    .WIDTH ($bits(lsb_entry_t)),
    .DEPTH (QDEPTH)
  ) u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .flush     (clr),
    .push      (lsb_push),
    .push_data (lsb_in),
    .pop       (grant_lsb),
    .head      (lsb_head),
    .count     (lsb_count)
  );

`ifdef CDB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (rdy && grant_alu) last_grant_d = CDB_SRC_ALU;
    if (rdy && grant_lsb) last_grant_d = CDB_SRC_LSB;
  end

  // Reset to LSB so the first contention after reset goes to the ALU.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= CDB_SRC_LSB;
    else     last_grant_q <= last_grant_d;
  end
`endif

  // Grants come only from entries already stored; nothing is forwarded
  // from the inputs, which fixes the latency at one cycle.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    if (!clr) begin
      if (alu_ne && lsb_ne) begin
`ifdef CDB_ROUND_ROBIN_EN
        grant_alu = (last_grant_q == CDB_SRC_LSB);
        grant_lsb = ~grant_alu;
`else
        grant_alu = 1'b1;
`endif
      end else begin
        grant_alu = alu_ne;
        grant_lsb = lsb_ne;
      end
    end
  end

  // With rdy low the broadcast is held so it is consumed once after resume.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_src_d   = cdb_src_q;
    cdb_entry_d = cdb_entry_q;
    if (rdy) begin
      cdb_valid_d = 1'b0;
      cdb_src_d   = CDB_SRC_ALU;
      cdb_entry_d = '0;
      if (grant_alu) begin
        cdb_valid_d = 1'b1;
        cdb_entry_d = alu_head;
      end else if (grant_lsb) begin
        cdb_valid_d         = 1'b1;
        cdb_src_d           = CDB_SRC_LSB;
        cdb_entry_d.rob_pos = lsb_head.rob_pos;
        cdb_entry_d.val     = lsb_head.val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= CDB_SRC_ALU;
      cdb_entry_q <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_entry_q <= cdb_entry_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_src     = cdb_src_q;
  assign cdb_rob_pos = cdb_entry_q.rob_pos;
  assign cdb_val     = cdb_entry_q.val;
  assign cdb_jump    = cdb_entry_q.jump;
  assign cdb_pc      = cdb_entry_q.pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a queue-based reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int QD = 2;

  logic        clk;
  logic        rst, rdy, clr;
  logic        alu_valid, alu_jump;
  logic [4:0]  alu_rob_pos;
  logic [31:0] alu_val, alu_pc;
  logic        alu_stall;
  logic        lsb_valid;
  logic [4:0]  lsb_rob_pos;
  logic [31:0] lsb_val;
  logic        lsb_stall;
  logic        cdb_valid, cdb_src, cdb_jump;
  logic [4:0]  cdb_rob_pos;
  logic [31:0] cdb_val, cdb_pc;

  cdb_arbiter #(.QDEPTH(QD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .clr         (clr),
    .alu_valid   (alu_valid),
    .alu_rob_pos (alu_rob_pos),
    .alu_val     (alu_val),
    .alu_jump    (alu_jump),
    .alu_pc      (alu_pc),
    .alu_stall   (alu_stall),
    .lsb_valid   (lsb_valid),
    .lsb_rob_pos (lsb_rob_pos),
    .lsb_val     (lsb_val),
    .lsb_stall   (lsb_stall),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .cdb_rob_pos (cdb_rob_pos),
    .cdb_val     (cdb_val),
    .cdb_jump    (cdb_jump),
    .cdb_pc      (cdb_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  pos;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } ent_t;

  ent_t        aq[$];
  ent_t        lq[$];
  logic        e_valid, e_src, e_jump;
  logic [4:0]  e_pos;
  logic [31:0] e_val, e_pc;
  logic        m_last;          // 1 = LSB granted last
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  lsb_seen[$];     // LSB rob positions observed on the bus

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    e_valid = 0; e_src = 0; e_pos = 0; e_val = 0; e_jump = 0; e_pc = 0;
  endtask

  // Applies the arbiter's rules to the model for the coming clock edge.
  task automatic model_edge();
    ent_t e;
    logic ga, gl, a_full, l_full;
    if (rst) begin
      aq.delete(); lq.delete(); clear_exp(); m_last = 1'b1;
    end else if (!rdy) begin
      // everything held
    end else if (clr) begin
      aq.delete(); lq.delete(); clear_exp();
    end else begin
      a_full = (aq.size() == QD);
      l_full = (lq.size() == QD);
      ga = 0; gl = 0;
      if (aq.size() > 0 && lq.size() > 0) begin
`ifdef CDB_ROUND_ROBIN_EN
        ga = m_last; gl = !m_last;
`else
        ga = 1;
`endif
      end else if (aq.size() > 0) ga = 1;
      else if (lq.size() > 0) gl = 1;
      clear_exp();
      if (ga) begin
        e = aq.pop_front();
        e_valid = 1; e_src = 0; e_pos = e.pos; e_val = e.val; e_jump = e.jump; e_pc = e.pc;
        m_last = 0;
      end else if (gl) begin
        e = lq.pop_front();
        e_valid = 1; e_src = 1; e_pos = e.pos; e_val = e.val;
        m_last = 1;
      end
      if (alu_valid && !a_full) aq.push_back('{alu_rob_pos, alu_val, alu_jump, alu_pc});
      if (lsb_valid && !l_full) lq.push_back('{lsb_rob_pos, lsb_val, 1'b0, 32'h0});
    end
  endtask

  // One clock: check drop flags with inputs settled, advance the model,
  // then check every output after the edge.
  task automatic step();
    #1;
    check("alu_drop", dut.alu_drop, rdy && !rst && !clr && alu_valid && (aq.size() == QD));
    check("lsb_drop", dut.lsb_drop, rdy && !rst && !clr && lsb_valid && (lq.size() == QD));
    model_edge();
    @(posedge clk);
    #1;
    check("cdb_valid",   cdb_valid,   e_valid);
    check("cdb_src",     cdb_src,     e_src);
    check("cdb_rob_pos", cdb_rob_pos, e_pos);
    check("cdb_val",     cdb_val,     e_val);
    check("cdb_jump",    cdb_jump,    e_jump);
    check("cdb_pc",      cdb_pc,      e_pc);
    check("alu_stall",   alu_stall,   aq.size() == QD);
    check("lsb_stall",   lsb_stall,   lq.size() == QD);
    if (cdb_valid && cdb_src) lsb_seen.push_back(cdb_rob_pos);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rdy = 1; clr = 0; alu_valid = 0; lsb_valid = 0;
  endtask

  task automatic set_alu(input logic [4:0] p, input logic [31:0] v, input logic j, input logic [31:0] pc);
    alu_valid = 1; alu_rob_pos = p; alu_val = v; alu_jump = j; alu_pc = pc;
  endtask

  task automatic set_lsb(input logic [4:0] p, input logic [31:0] v);
    lsb_valid = 1; lsb_rob_pos = p; lsb_val = v;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle();
    alu_rob_pos = 0; alu_val = 0; alu_jump = 0; alu_pc = 0;
    lsb_rob_pos = 0; lsb_val = 0;
    m_last = 1'b1;
    clear_exp();
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_valid", cdb_valid, 0);
    check("rst_stalls", {alu_stall, lsb_stall}, 2'b00);

    // Single ALU result, one-cycle latency
    set_alu(5'h13, 32'hDEAD_BEEF, 1'b1, 32'h100);
    step();
    check("lat_edgeN_valid", cdb_valid, 0);
    idle(); step();
    check("lat_valid", cdb_valid, 1);
    check("lat_src", cdb_src, 0);
    check("lat_pos", cdb_rob_pos, 5'h13);
    check("lat_val", cdb_val, 32'hDEAD_BEEF);
    check("lat_jump", cdb_jump, 1);
    check("lat_pc", cdb_pc, 32'h100);
    step();
    check("lat_n2_valid", cdb_valid, 0);

    // Same-edge contention after reset: ALU first, then LSB
    do_reset();
    set_alu(5'd1, 32'h11, 1'b0, 32'h0);
    set_lsb(5'd2, 32'h22);
    step();
    idle(); step();
    check("cont1_src", cdb_src, 0);
    check("cont1_pos", cdb_rob_pos, 5'd1);
    step();
    check("cont2_src", cdb_src, 1);
    check("cont2_pos", cdb_rob_pos, 5'd2);
    check("cont2_jump_pc", {cdb_jump, cdb_pc}, 33'h0);
    step();

    // Fixed priority: LSB starved while ALU queue stays non-empty
    set_lsb(5'd9, 32'h99);
    for (int i = 0; i < 6; i++) begin
      set_alu(5'(16 + i), 32'(i), 1'b0, 32'(4 * i));
      step();
      lsb_valid = 0;
`ifndef CDB_ROUND_ROBIN_EN
      if (i > 0) check("alu_prio_src", cdb_src, 0);
`endif
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    // LSB overflow while ALU keeps winning
    do_reset();
    lsb_seen.delete();
    for (int i = 0; i < 6; i++) begin
      set_alu(5'(20 + i), 32'h1000 + 32'(i), 1'b0, 32'h0);
      if (i < 3) set_lsb(5'(3 + i), 32'h300 + 32'(i));
      else lsb_valid = 0;
`ifndef CDB_ROUND_ROBIN_EN
      if (i == 2) begin
        #1;
        check("ovf_drop_flag", dut.lsb_drop, 1);
      end
`endif
      step();
`ifndef CDB_ROUND_ROBIN_EN
      if (i == 1) check("ovf_stall", lsb_stall, 1);
`endif
    end
    idle();
    for (int i = 0; i < 6; i++) step();
`ifndef CDB_ROUND_ROBIN_EN
    check("ovf_count", lsb_seen.size(), 2);
    if (lsb_seen.size() == 2) begin
      check("ovf_order0", lsb_seen[0], 5'd3);
      check("ovf_order1", lsb_seen[1], 5'd4);
    end
`endif

    // Flush with queued entries and a same-cycle push
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_alu(5'(10 + i), 32'hA0 + 32'(i), 1'b0, 32'h0);
      set_lsb(5'(12 + i), 32'hB0 + 32'(i));
      step();
    end
    set_alu(5'd30, 32'hC0, 1'b1, 32'h40);
    lsb_valid = 0;
    clr = 1;
    step();
    check("clr_valid", cdb_valid, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check("clr_empty", cdb_valid, 0);
    end

    // Stall with rdy low while a result is on the bus
    do_reset();
    set_alu(5'd7, 32'h77, 1'b0, 32'h700);
    step();
    set_alu(5'd8, 32'h88, 1'b0, 32'h800);
    step();
    check("hold_pre_pos", cdb_rob_pos, 5'd7);
    idle();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", cdb_valid, 1);
      check("hold_pos", cdb_rob_pos, 5'd7);
    end
    rdy = 1;
    step();
    check("resume_pos", cdb_rob_pos, 5'd8);
    check("resume_valid", cdb_valid, 1);
    step();

    // Reset with both queues loaded, then contention goes to ALU
    for (int i = 0; i < 4; i++) begin
      set_alu(5'(i), 32'(i), 1'b1, 32'(i));
      set_lsb(5'(8 + i), 32'(8 + i));
      step();
    end
    rst = 1;
    step();
    check("rst_mid_out", {cdb_valid, cdb_src, cdb_rob_pos, cdb_jump}, 8'h0);
    check("rst_mid_val_pc", {cdb_val, cdb_pc}, 64'h0);
    check("rst_mid_stalls", {alu_stall, lsb_stall}, 2'b00);
    rst = 0;
    set_alu(5'd14, 32'hE, 1'b0, 32'h0);
    set_lsb(5'd15, 32'hF);
    step();
    idle(); step();
    check("post_rst_src", cdb_src, 0);
    check("post_rst_pos", cdb_rob_pos, 5'd14);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      clr       = ($urandom_range(0, 99) < 5);
      rdy       = ($urandom_range(0, 99) < 88);
      alu_valid = ($urandom_range(0, 99) < 55);
      lsb_valid = ($urandom_range(0, 99) < 45);
      alu_rob_pos = 5'($urandom);
      alu_val     = $urandom;
      alu_jump    = 1'($urandom);
      alu_pc      = $urandom;
      lsb_rob_pos = 5'($urandom);
      lsb_val     = $urandom;
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, meaning entries per source queue (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-004 SHALL have port rdy  input  1  global ready; low freezes all state and outputs.
REQ-005 SHALL have port clr  input  1  misprediction flush from ROB.
REQ-006 SHALL have ports alu_valid/alu_rob_pos/alu_val/alu_jump/alu_pc  input  1/5/32/1/32  ALU result.
REQ-007 SHALL have port alu_stall  output  1  ALU queue full, do not present.
REQ-008 SHALL have ports lsb_valid/lsb_rob_pos/lsb_val  input  1/5/32  load result.
REQ-009 SHALL have port lsb_stall  output  1  LSB queue full, do not present.
REQ-010 SHALL have ports cdb_valid/cdb_src/cdb_rob_pos/cdb_val/cdb_jump/cdb_pc  output  1/1/5/32/1/32  registered broadcast to ROB/RS/LSB; cdb_src 0=ALU, 1=LSB.

Function
REQ-011 SHALL push a source's fields into its FIFO at the edge where valid=1, rdy=1, clr=0, rst=0.
REQ-012 SHALL drive stall = (count == QDEPTH) from current count; a same-cycle pop does not clear stall.
REQ-013 SHALL ignore valid while stall=1 (entry dropped, count unchanged); a simulation-only error SHALL flag it.
REQ-014 SHALL grant at most one non-empty FIFO per cycle, pop its head, and register it to the cdb_* outputs with cdb_valid=1 at the same edge.
REQ-015 SHALL have a latency of 1 cycle: input at edge N with empty queues -> cdb_valid at edge N+1; an empty queue SHALL NOT be bypassed combinationally.
REQ-016 SHALL drive cdb_valid=0 and zero all other cdb_* outputs in cycles with no grant.
REQ-017 SHALL zero cdb_jump and cdb_pc for LSB grants.
REQ-018 SHALL support push and pop on the same FIFO in one edge; count is unchanged; read and write pointers wrap modulo QDEPTH.
REQ-019 SHALL, on clr=1: empty both FIFOs, discard same-cycle inputs, and set cdb_valid=0 at the next edge; last_grant is unchanged.
REQ-020 SHALL, with rdy=0, hold every register, including a valid cdb output, so that the output is consumed exactly once after rdy returns.
REQ-021 SHALL preserve per-source order; there is no cross-source ordering guarantee.

Reset
REQ-022 SHALL, on rst=1 at the edge: both counts=0, pointers=0, cdb_valid=0, all cdb_* outputs=0, last_grant=LSB; stalls read 0 the next cycle.
REQ-023 SHALL let rst mid-operation discard all queued entries, with rst taking precedence over clr and rdy.

Configuration
REQ-024 SHALL, with CDB_ROUND_ROBIN_EN defined, resolve contention (both queues non-empty) against last_grant: the source not granted last wins, and last_grant updates on every grant.
REQ-025 SHALL, without CDB_ROUND_ROBIN_EN, always grant ALU when both are non-empty; last_grant is not implemented.

Structure
REQ-026 SHALL take ROB_WRAP_POS_TYPE, DATA_TYPE, ADDR_TYPE, TRUE/FALSE from the shared definition.v; CDB_SRC_ALU/CDB_SRC_LSB constants SHALL be added there.
REQ-027 SHALL instantiate a generic sub-module cdb_fifo (parameterised width/depth; push, pop, head, count, flush) twice.

Verification
REQ-028 SHALL verify: ALU push rob_pos=5'h13, val=32'hDEAD_BEEF, jump=1, pc=32'h100 at edge N -> at edge N+1 cdb_valid=1, src=0, matching fields; at N+2 cdb_valid=0.
REQ-029 SHALL verify: ALU(pos 1) and LSB(pos 2) pushed same edge after reset, round robin on -> grants ALU at N+1, LSB at N+2; macro off with ALU pushing every cycle -> LSB never granted while the ALU queue is non-empty.
REQ-030 SHALL verify: LSB pushes pos 3,4,5 on consecutive edges while ALU continuously wins with the macro off -> lsb_stall=1 after the second entry; third push dropped and error flagged; output order 3,4.
REQ-031 SHALL verify: two entries queued per source, clr pulsed with a new ALU push -> cdb_valid=0 from the next edge; no queued entry ever appears.
REQ-032 SHALL verify: rdy=0 for 3 cycles while cdb_valid=1 (pos 7) -> outputs held constant; after rdy=1, pos 7 is presented for exactly one rdy cycle, then the next entry follows.
REQ-033 SHALL verify: rst asserted with both queues full -> next edge all outputs 0, stalls 0; first post-reset contention is granted to ALU.
